// File: rtl/ysyx_22040759_trap_seq_if.sv
// ============================================================================
// Module   : ysyx_22040759_trap_seq_if
// Brief    : Execute-stage request, CSR write port and redirect bundle for
//            the trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_22040759_trap_seq_if #(
    parameter int XLEN    = 64,
    parameter int ETYPE_W = 17
);
    logic               ex_valid;
    logic [ETYPE_W-1:0] ex_type;
    logic [XLEN-1:0]    ex_pc;
    logic               timer_irq;
    logic               clu_wen;
    logic [11:0]        clu_waddr;
    logic [XLEN-1:0]    clu_wdata;
    logic [XLEN-1:0]    mstatus_i;
    logic [XLEN-1:0]    mie_i;
    logic [XLEN-1:0]    mtvec_i;
    logic [XLEN-1:0]    mepc_i;
    logic               csr_wen;
    logic [11:0]        csr_waddr;
    logic [XLEN-1:0]    csr_wdata;
    logic               stall;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               flush;
    logic               busy;

    // Pipeline / CSR-file side that drives requests and consumes outputs.
    modport master (
        output ex_valid, ex_type, ex_pc, timer_irq,
        output clu_wen, clu_waddr, clu_wdata,
        output mstatus_i, mie_i, mtvec_i, mepc_i,
        input  csr_wen, csr_waddr, csr_wdata,
        input  stall, redirect_valid, redirect_pc, flush, busy
    );

    // Trap sequencer side.
    modport slave (
        input  ex_valid, ex_type, ex_pc, timer_irq,
        input  clu_wen, clu_waddr, clu_wdata,
        input  mstatus_i, mie_i, mtvec_i, mepc_i,
        output csr_wen, csr_waddr, csr_wdata,
        output stall, redirect_valid, redirect_pc, flush, busy
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_22040759_trap_seq.sv
// ============================================================================
// Module   : ysyx_22040759_trap_seq
// Brief    : Trap sequencer owning the CSR write port during trap entry/return;
//            optional vectored interrupts via YSYX_22040759_TRAP_VECTORED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040759_trap_seq #(
    parameter int XLEN    = 64,
    parameter int ETYPE_W = 17
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    ysyx_22040759_trap_seq_if.slave         bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MSTATUS = 3'd3,
        REDIRECT  = 3'd4
    } state_t;

    localparam logic [2:0]  c_K_IRQ    = 3'd0;
    localparam logic [2:0]  c_K_ILL    = 3'd1;
    localparam logic [2:0]  c_K_ECALL  = 3'd2;
    localparam logic [2:0]  c_K_EBREAK = 3'd3;
    localparam logic [2:0]  c_K_MRET   = 3'd4;
    localparam logic [2:0]  c_K_FENCEI = 3'd5;

    localparam logic [11:0] c_A_MSTATUS = 12'h300;
    localparam logic [11:0] c_A_MEPC    = 12'h341;
    localparam logic [11:0] c_A_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] c_CAUSE_IRQ    = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
    localparam logic [XLEN-1:0] c_CAUSE_ILL    = XLEN'(2);
    localparam logic [XLEN-1:0] c_CAUSE_EBREAK = XLEN'(3);
    localparam logic [XLEN-1:0] c_CAUSE_ECALL  = XLEN'(11);

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_cause;
    logic [2:0]        r_kind;

    logic              w_irq_take;
    logic              w_accept;
    logic [2:0]        w_kind;
    logic [XLEN-1:0]   w_cause;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_trap_pc;
    logic [XLEN-1:0]   w_mstatus_trap;
    logic [XLEN-1:0]   w_mstatus_mret;

    logic              w_csr_wen;
    logic [11:0]       w_csr_waddr;
    logic [XLEN-1:0]   w_csr_wdata;
    logic              w_stall;
    logic              w_redirect_valid;
    logic [XLEN-1:0]   w_redirect_pc;

    // Bits of ex_type/mtvec that carry no meaning here.
    logic w_unused;
    assign w_unused = ^{bus.ex_type[ETYPE_W-1:6], bus.ex_type[4], bus.mtvec_i[1:0]};

    assign w_irq_take = bus.timer_irq & bus.mstatus_i[3] & bus.mie_i[7] & bus.ex_valid;
    assign w_accept   = w_irq_take |
                        (bus.ex_valid & (bus.ex_type[0] | bus.ex_type[1] | bus.ex_type[2] |
                                         bus.ex_type[3] | bus.ex_type[5]));

    always_comb begin
        w_kind  = c_K_FENCEI;
        w_cause = '0;
        if (w_irq_take) begin
            w_kind  = c_K_IRQ;
            w_cause = c_CAUSE_IRQ;
        end else if (bus.ex_type[3]) begin
            w_kind  = c_K_ILL;
            w_cause = c_CAUSE_ILL;
        end else if (bus.ex_type[0]) begin
            w_kind  = c_K_ECALL;
            w_cause = c_CAUSE_ECALL;
        end else if (bus.ex_type[1]) begin
            w_kind  = c_K_EBREAK;
            w_cause = c_CAUSE_EBREAK;
        end else if (bus.ex_type[2]) begin
            w_kind  = c_K_MRET;
        end
    end

    always_comb begin
        w_mstatus_trap        = bus.mstatus_i;
        w_mstatus_trap[7]     = bus.mstatus_i[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;
        w_mstatus_mret        = bus.mstatus_i;
        w_mstatus_mret[3]     = bus.mstatus_i[7];
        w_mstatus_mret[7]     = 1'b1;
        w_mstatus_mret[12:11] = 2'b11;
    end

    assign w_base = {bus.mtvec_i[XLEN-1:2], 2'b00};

`ifdef YSYX_22040759_TRAP_VECTORED_EN
    // Vectored mode only offsets interrupts; cause 7 lands at base + 28.
    assign w_trap_pc = (r_kind == c_K_IRQ && bus.mtvec_i[1:0] == 2'b01)
                     ? w_base + XLEN'(28) : w_base;
`else
    assign w_trap_pc = w_base;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
            r_kind  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_accept) begin
                r_pc    <= bus.ex_pc;
                r_cause <= w_cause;
                r_kind  <= w_kind;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_csr_wen        = 1'b0;
        w_csr_waddr      = '0;
        w_csr_wdata      = '0;
        w_stall          = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_kind == c_K_MRET)        w_next = W_MSTATUS;
                    else if (w_kind == c_K_FENCEI) w_next = REDIRECT;
                    else                           w_next = W_MEPC;
                end else begin
                    w_stall     = 1'b0;
                    w_csr_wen   = bus.clu_wen;
                    w_csr_waddr = bus.clu_waddr;
                    w_csr_wdata = bus.clu_wdata;
                end
            end
            W_MEPC: begin
                w_csr_wen   = 1'b1;
                w_csr_waddr = c_A_MEPC;
                w_csr_wdata = r_pc;
                w_next      = W_MCAUSE;
            end
            W_MCAUSE: begin
                w_csr_wen   = 1'b1;
                w_csr_waddr = c_A_MCAUSE;
                w_csr_wdata = r_cause;
                w_next      = W_MSTATUS;
            end
            W_MSTATUS: begin
                w_csr_wen   = 1'b1;
                w_csr_waddr = c_A_MSTATUS;
                w_csr_wdata = (r_kind == c_K_MRET) ? w_mstatus_mret : w_mstatus_trap;
                w_next      = REDIRECT;
            end
            REDIRECT: begin
                w_redirect_valid = 1'b1;
                if (r_kind == c_K_MRET)        w_redirect_pc = bus.mepc_i;
                else if (r_kind == c_K_FENCEI) w_redirect_pc = r_pc + XLEN'(4);
                else                           w_redirect_pc = w_trap_pc;
                w_next = IDLE;
            end
            default: begin
                w_stall = 1'b0;
                w_next  = IDLE;
            end
        endcase
    end

    assign bus.csr_wen        = w_csr_wen;
    assign bus.csr_waddr      = w_csr_waddr;
    assign bus.csr_wdata      = w_csr_wdata;
    assign bus.stall          = w_stall;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;
    assign bus.flush          = w_redirect_valid;
    assign bus.busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040759_trap_seq.sv
// ============================================================================
// Module   : tb_ysyx_22040759_trap_seq
// Brief    : Directed self-checking bench for the trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040759_trap_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    ysyx_22040759_trap_seq_if #(.XLEN(64), .ETYPE_W(17)) u_if ();

    ysyx_22040759_trap_seq #(.XLEN(64), .ETYPE_W(17)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (u_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic en, input logic [11:0] a,
                           input logic [63:0] d);
        check({tag, ".wen"}, {63'd0, u_if.csr_wen}, {63'd0, en});
        check({tag, ".addr"}, {52'd0, u_if.csr_waddr}, {52'd0, a});
        check({tag, ".data"}, u_if.csr_wdata, d);
    endtask

    task automatic check_ctl(input string tag, input logic st, input logic rv,
                             input logic bz);
        check({tag, ".stall"}, {63'd0, u_if.stall}, {63'd0, st});
        check({tag, ".redir"}, {63'd0, u_if.redirect_valid}, {63'd0, rv});
        check({tag, ".flush"}, {63'd0, u_if.flush}, {63'd0, rv});
        check({tag, ".busy"}, {63'd0, u_if.busy}, {63'd0, bz});
    endtask

    // Advance one cycle; inputs change and outputs are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        u_if.ex_valid  = 1'b0;
        u_if.ex_type   = '0;
        u_if.timer_irq = 1'b0;
        u_if.clu_wen   = 1'b0;
        u_if.clu_waddr = '0;
        u_if.clu_wdata = '0;
    endtask

    task automatic run_trap(input string tag, input logic [63:0] pc, input logic [63:0] cause,
                            input logic [63:0] mst, input logic [63:0] target);
        check_ctl({tag, ".T"}, 1'b1, 1'b0, 1'b0);
        check_w({tag, ".T"}, 1'b0, 12'h000, 64'h0);
        step(); idle_inputs(); #1;
        check_w({tag, ".mepc"}, 1'b1, 12'h341, pc);
        check_ctl({tag, ".T1"}, 1'b1, 1'b0, 1'b1);
        step();
        check_w({tag, ".mcause"}, 1'b1, 12'h342, cause);
        step();
        check_w({tag, ".mstatus"}, 1'b1, 12'h300, mst);
        step();
        check_w({tag, ".T4"}, 1'b0, 12'h000, 64'h0);
        check_ctl({tag, ".T4"}, 1'b1, 1'b1, 1'b1);
        check({tag, ".rpc"}, u_if.redirect_pc, target);
        step();
        check_ctl({tag, ".T5"}, 1'b0, 1'b0, 1'b0);
    endtask

    logic [63:0] vec_target;

    initial begin
        idle_inputs();
        u_if.ex_pc     = '0;
        u_if.mstatus_i = '0;
        u_if.mie_i     = '0;
        u_if.mtvec_i   = '0;
        u_if.mepc_i    = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_w("reset", 1'b0, 12'h000, 64'h0);

        // Plain CSR instruction passes straight through.
        u_if.clu_wen = 1'b1; u_if.clu_waddr = 12'h340; u_if.clu_wdata = 64'h55;
        #1;
        check_w("clu", 1'b1, 12'h340, 64'h55);
        check_ctl("clu", 1'b0, 1'b0, 1'b0);
        step(); idle_inputs();

        // ecall
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h1; u_if.ex_pc = 64'h8000_0010;
        u_if.mtvec_i = 64'h8000_1000; u_if.mstatus_i = 64'h8;
        #1;
        run_trap("ecall", 64'h8000_0010, 64'd11, 64'h1880, 64'h8000_1000);

        // mret
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h4; u_if.ex_pc = 64'h8000_0100;
        u_if.mstatus_i = 64'h80; u_if.mepc_i = 64'h8000_0020;
        #1;
        check_ctl("mret.T", 1'b1, 1'b0, 1'b0);
        step(); idle_inputs(); #1;
        check_w("mret.mstatus", 1'b1, 12'h300, 64'h1888);
        step();
        check_ctl("mret.T2", 1'b1, 1'b1, 1'b1);
        check("mret.rpc", u_if.redirect_pc, 64'h8000_0020);
        step();
        check_ctl("mret.T3", 1'b0, 1'b0, 1'b0);

        // Timer interrupt beats a simultaneous ecall and CSR write.
`ifdef YSYX_22040759_TRAP_VECTORED_EN
        vec_target = 64'h8000_101C;
`else
        vec_target = 64'h8000_1000;
`endif
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h1; u_if.ex_pc = 64'h8000_0200;
        u_if.timer_irq = 1'b1; u_if.mie_i = 64'h80; u_if.mstatus_i = 64'h8;
        u_if.mtvec_i = 64'h8000_1001;
        u_if.clu_wen = 1'b1; u_if.clu_waddr = 12'h340; u_if.clu_wdata = 64'h77;
        #1;
        run_trap("irq", 64'h8000_0200, 64'h8000_0000_0000_0007, 64'h1880, vec_target);

        // Same stimulus with MIE clear: ecall taken, exception uses base.
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h1; u_if.ex_pc = 64'h8000_0300;
        u_if.timer_irq = 1'b1; u_if.mstatus_i = 64'h0;
        u_if.clu_wen = 1'b1; u_if.clu_waddr = 12'h340; u_if.clu_wdata = 64'h77;
        #1;
        run_trap("irqoff", 64'h8000_0300, 64'd11, 64'h1800, 64'h8000_1000);

        // Illegal beats ecall and ebreak.
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'hB; u_if.ex_pc = 64'h8000_0400;
        u_if.mstatus_i = 64'h8;
        #1;
        run_trap("illegal", 64'h8000_0400, 64'd2, 64'h1880, 64'h8000_1000);

        // ebreak alone
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h2; u_if.ex_pc = 64'h8000_0500;
        u_if.mstatus_i = 64'h0;
        #1;
        run_trap("ebreak", 64'h8000_0500, 64'd3, 64'h1800, 64'h8000_1000);

        // Ignored type bit alone does nothing.
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h10;
        #1;
        check_ctl("bit4", 1'b0, 1'b0, 1'b0);
        step(); idle_inputs();

        // fence.i with PC wrap
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h20; u_if.ex_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check_ctl("fencei.T", 1'b1, 1'b0, 1'b0);
        step(); idle_inputs(); #1;
        check_w("fencei.T1", 1'b0, 12'h000, 64'h0);
        check_ctl("fencei.T1", 1'b1, 1'b1, 1'b1);
        check("fencei.rpc", u_if.redirect_pc, 64'h0);
        step();
        check_ctl("fencei.T2", 1'b0, 1'b0, 1'b0);

        // Reset during W_MCAUSE.
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h1; u_if.ex_pc = 64'h8000_0600;
        step(); idle_inputs(); #1;
        check_w("rst.mepc", 1'b1, 12'h341, 64'h8000_0600);
        step();
        check("rst.inmcause", {52'd0, u_if.csr_waddr}, 64'h342);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_ctl("rst.after", 1'b0, 1'b0, 1'b0);
        check_w("rst.after", 1'b0, 12'h000, 64'h0);
        check("rst.rpc", u_if.redirect_pc, 64'h0);

        // Normal ecall after reset.
        u_if.ex_valid = 1'b1; u_if.ex_type = 17'h1; u_if.ex_pc = 64'h8000_0700;
        u_if.mstatus_i = 64'h8;
        #1;
        run_trap("post", 64'h8000_0700, 64'd11, 64'h1880, 64'h8000_1000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22040759_trap_seq.md
Name: ysyx_22040759_trap_seq

Overview:
- Trap sequencer between the execute-stage CSR logic unit and the single-write-port CSR file.
- Accepts exception requests (ecall, ebreak, mret, illegal instruction, fence.i) and the CLINT timer interrupt.
- Arbitrates the CSR write port between ordinary CSR-instruction writes and its own multi-cycle trap-entry/return writes (mepc, mcause, mstatus).
- Stalls the pipeline while sequencing, then issues a one-cycle PC redirect plus flush.

Parameters:
XLEN, 64, data/address width of CSRs and PC
ETYPE_W, 17, width of the exception-type vector from the CSR logic unit

Ports:
clock  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ex_valid  in  1  execute-stage instruction valid this cycle
ex_type  in  ETYPE_W  bit0 ecall, bit1 ebreak, bit2 mret, bit3 illegal, bit5 fence.i; other bits ignored
ex_pc  in  XLEN  PC of the execute-stage instruction
timer_irq  in  1  CLINT machine timer pending (level)
clu_wen  in  1  CSR-instruction write enable
clu_waddr  in  12  CSR-instruction write address
clu_wdata  in  XLEN  CSR-instruction write data
mstatus_i, mie_i, mtvec_i, mepc_i  in  XLEN each  current CSR values
csr_wen  out  1  CSR file write enable
csr_waddr  out  12  CSR file write address
csr_wdata  out  XLEN  CSR file write data
stall  out  1  hold IF/ID/EX
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target
flush  out  1  flush younger instructions; equals redirect_valid
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT. Reset: state=IDLE; latched pc/cause/kind=0; all outputs 0.
- irq_take = timer_irq & mstatus_i[3] & mie_i[7] & ex_valid.
- accept (IDLE only) = irq_take | (ex_valid & |ex_type bits {0,1,2,3,5}).
- Priority: interrupt > illegal > ecall > ebreak > mret > fence.i. Latch ex_pc and the selected kind at accept.
- mcause: interrupt 0x8000000000000007; illegal 2; ebreak 3; ecall 11.
- IDLE without accept: csr_w* = clu_w* passthrough. With accept: csr_wen=0 (instruction CSR write suppressed) and stall=1 combinationally.
- Trap (irq/illegal/ecall/ebreak): T accept -> W_MEPC (write 0x341 = latched pc) -> W_MCAUSE (0x342 = cause) -> W_MSTATUS (0x300: MPIE[7]<=MIE[3], MIE<=0, MPP[12:11]<=11, other bits from mstatus_i) -> REDIRECT (redirect_pc = {mtvec_i[63:2],2'b00}) -> IDLE. Redirect occurs at T+4.
- mret: accept -> W_MSTATUS (MIE<=MPIE, MPIE<=1, MPP<=11) -> REDIRECT (redirect_pc = mepc_i) -> IDLE.
- fence.i: accept -> REDIRECT (redirect_pc = latched pc + 4), no CSR writes.
- stall=1 from the accept cycle through the REDIRECT cycle inclusive. redirect_valid/flush=1 only in REDIRECT.
- In non-IDLE states, clu_wen, ex_valid, ex_type and timer_irq are ignored. The trap sequencer owns the write port.
- Reset asserted in any state: next cycle IDLE with all outputs 0; partial CSR writes are not undone.
- PC+4 wraps modulo 2^64.

Optional Feature:
YSYX_22040759_TRAP_VECTORED_EN:
- Defined: for interrupt traps with mtvec_i[1:0]==01, redirect_pc = {mtvec_i[63:2],2'b00} + 4*7. Exceptions always use the base address.
- Undefined: mtvec_i[1:0] is ignored and every trap redirects to the base address.

Test Plan:
- ecall at ex_pc=0x80000010, mtvec=0x80001000, mstatus=0x8 -> writes 0x341=0x80000010, 0x342=11, 0x300=0x1880 on T+1..T+3. T+4 redirect_pc=0x80001000. stall high T..T+4.
- mret with mstatus=0x80, mepc=0x80000020 -> T+1 writes 0x300=0x1888. T+2 redirect_pc=0x80000020, flush=1.
- timer_irq=1, mie=0x80, mstatus=0x8, simultaneous ecall and clu_wen=1 -> CSR write suppressed, mcause=0x8000000000000007, mepc=ex_pc. Same stimulus with mstatus=0x0 -> ecall trap taken, mcause=11.
- CSR instruction only (clu_wen=1, addr 0x340, data 0x55) -> csr_wen=1, addr 0x340, data 0x55 same cycle; stall=0.
- fence.i at pc=0xFFFFFFFFFFFFFFFC -> no CSR writes, redirect_pc=0 at T+1. Vectored build: irq with mtvec=0x80001001 -> redirect 0x8000101C.
- reset asserted during W_MCAUSE -> next cycle IDLE, outputs 0. A later ecall sequences normally.
